// File: rtl/i2s_stream_tx.sv
// I2S / left-justified stereo serializer with a one-entry sample-pair holding buffer.
// The frame word is latched at each frame load, and the output bits are shifted out MSB first on sclk falling edges.
module i2s_stream_tx #(
    parameter int WIDTH  = 16,
    parameter int SLOT   = 32,
    parameter int CLKDIV = 2
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             enable,
    input  logic             mode,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_left,
    input  logic [WIDTH-1:0] tx_right,
    output logic             sclk,
    output logic             lrclk,
    output logic             sd,
    output logic             frame_start,
    output logic             underrun
);

    localparam int FBITS = 2 * SLOT;
    localparam int KW    = $clog2(FBITS);
    localparam int DW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(FBITS - 1);
    localparam logic [KW-1:0] K_SLOT   = KW'(SLOT);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    logic [DW-1:0]      div_r;
    logic [KW-1:0]      k_r;
    logic               sclk_r;
    logic               lrclk_r;
    logic               sd_r;
    logic               frame_start_r;
    logic               underrun_r;
    logic               mode_r;
    logic [FBITS-1:0]   shift_r;
    logic [2*WIDTH-1:0] buf_r;
    logic               buf_full_r;
    logic               ready_r;

    logic               run_s;
    logic               hs_s;
    logic               tc_s;
    logic               fall_s;
    logic               wrap_s;
    logic               load_s;
    logic [KW-1:0]      k_next_s;
    logic [FBITS-1:0]   frame_s;
    logic               load_sd_s;

    // MSB-align one sample inside its slot, zero padding the tail
    function automatic logic [SLOT-1:0] slot_word(input logic [WIDTH-1:0] sample);
        logic [SLOT+WIDTH-1:0] ext;
        ext = {sample, {SLOT{1'b0}}};
        return ext[SLOT+WIDTH-1 -: SLOT];
    endfunction

    // Handshake, divider terminal count, frame-boundary strobes and the next frame word
    always_comb begin
        run_s    = (state_r == RUN);
        hs_s     = tx_valid & ready_r;
        tc_s     = run_s & (div_r == DIV_LAST);
        fall_s   = tc_s & sclk_r;
        wrap_s   = fall_s & (k_r == K_LAST);
        load_s   = enable & (~run_s | wrap_s);
        k_next_s = k_r + KW'(1'b1);
        if (buf_full_r) begin
            frame_s = {slot_word(buf_r[2*WIDTH-1:WIDTH]), slot_word(buf_r[WIDTH-1:0])};
        end else begin
            frame_s = {FBITS{1'b0}};
        end
        // I2S mode repeats the last bit of the running frame at k=0 (zero when starting from idle)
        if (mode) begin
            load_sd_s = frame_s[FBITS-1];
        end else begin
            load_sd_s = run_s & shift_r[FBITS-1];
        end
    end

    // One-entry holding buffer; a load-cycle handshake refills it and never bypasses into the frame
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            buf_r      <= {(2*WIDTH){1'b0}};
            buf_full_r <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            if (hs_s) begin
                buf_r      <= {tx_left, tx_right};
                buf_full_r <= 1'b1;
                ready_r    <= 1'b0;
            end else if (load_s) begin
                buf_full_r <= 1'b0;
                ready_r    <= 1'b1;
            end
        end
    end

    // Control FSM, bit-clock divider and serializer; every output comes from here
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r       <= IDLE;
            div_r         <= {DW{1'b0}};
            k_r           <= {KW{1'b0}};
            sclk_r        <= 1'b0;
            lrclk_r       <= 1'b0;
            sd_r          <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
            mode_r        <= 1'b0;
            shift_r       <= {FBITS{1'b0}};
        end else begin
            frame_start_r <= load_s;
            underrun_r    <= load_s & ~buf_full_r;
            case (state_r)
                IDLE: begin
                    div_r   <= {DW{1'b0}};
                    k_r     <= {KW{1'b0}};
                    sclk_r  <= 1'b0;
                    lrclk_r <= 1'b0;
                    if (enable) begin
                        state_r <= RUN;
                        shift_r <= frame_s;
                        mode_r  <= mode;
                        sd_r    <= load_sd_s;
                    end else begin
                        sd_r    <= 1'b0;
                    end
                end
                RUN: begin
                    if (tc_s) begin
                        div_r  <= {DW{1'b0}};
                        sclk_r <= ~sclk_r;
                    end else begin
                        div_r  <= div_r + DW'(1'b1);
                    end
                    if (wrap_s) begin
                        k_r     <= {KW{1'b0}};
                        lrclk_r <= 1'b0;
                        if (enable) begin
                            shift_r <= frame_s;
                            mode_r  <= mode;
                            sd_r    <= load_sd_s;
                        end else begin
                            state_r <= IDLE;
                            shift_r <= {FBITS{1'b0}};
                            sd_r    <= 1'b0;
                        end
                    end else if (fall_s) begin
                        // shift_r MSB holds bit k_r; left-justified shows bit k_r+1, I2S shows bit k_r
                        k_r     <= k_next_s;
                        lrclk_r <= (k_next_s >= K_SLOT);
                        shift_r <= {shift_r[FBITS-2:0], 1'b0};
                        sd_r    <= mode_r ? shift_r[FBITS-2] : shift_r[FBITS-1];
                    end
                end
                default: begin
                    state_r <= IDLE;
                    div_r   <= {DW{1'b0}};
                    k_r     <= {KW{1'b0}};
                    sclk_r  <= 1'b0;
                    lrclk_r <= 1'b0;
                    sd_r    <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready    = ready_r;
    assign sclk        = sclk_r;
    assign lrclk       = lrclk_r;
    assign sd          = sd_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;

endmodule

// File: doc/i2s_stream_tx.md
I2S_STREAM_TX -- requirements
Module: i2s_stream_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock and nreset.
REQ-002 Parameter WIDTH SHALL default to 16 and set the sample bits per channel; legal range is WIDTH >= 1.
REQ-003 Parameter SLOT SHALL default to 32 and set the SCLK periods per channel slot; legal range is SLOT >= WIDTH and SLOT >= 2.
REQ-004 Parameter CLKDIV SHALL default to 2 and set the clock cycles per SCLK half-period; legal range is CLKDIV >= 1.
REQ-005 Ports (name, direction, width, meaning) SHALL be:
- clock  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- enable  in  1  run request, level-sensitive.
- mode  in  1  0 = I2S (one-bit delay), 1 = left-justified.
- tx_valid  in  1  a sample pair is offered.
- tx_ready  out  1  the holding buffer is empty.
- tx_left  in  WIDTH  left sample, MSB first.
- tx_right  in  WIDTH  right sample, MSB first.
- sclk  out  1  serial bit clock.
- lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- sd  out  1  serial data.
- frame_start  out  1  one-cycle pulse on each frame load.
- underrun  out  1  one-cycle pulse when a frame is loaded from an empty buffer.

Function
REQ-006 The block SHALL hold a one-entry holding buffer; tx_ready SHALL equal NOT buffer_full, driven from a register.
REQ-007 A cycle with tx_valid=1 and tx_ready=1 SHALL capture {tx_left, tx_right} into the buffer and set buffer_full the next cycle.
REQ-008 The FSM SHALL have two states, IDLE and RUN; reset enters IDLE.
REQ-009 In IDLE, the block SHALL drive sclk=0, lrclk=0, sd=0 and hold the divider counter and bit index k at 0.
REQ-010 In IDLE with enable=1, the block SHALL perform a frame load and enter RUN the next cycle.
REQ-011 The divider SHALL count 0..CLKDIV-1 in RUN and toggle sclk at terminal count.
- sclk period = 2*CLKDIV clocks; the first rise comes CLKDIV clocks after RUN entry.
REQ-012 Each sclk 1->0 transition SHALL advance k, modulo 2*SLOT; lrclk and sd SHALL change only on these falling events or on a frame load.
REQ-013 lrclk SHALL equal (k >= SLOT) in both modes.
REQ-014 Frame word F (2*SLOT bits) SHALL be built as follows:
- left sample MSB-aligned in slot 0, zero padded to SLOT bits;
- then right sample likewise in slot 1.
REQ-015 In mode=1, sd SHALL equal F bit k, counted MSB first.
REQ-016 In mode=0, sd SHALL equal F bit k-1; at k=0, sd SHALL equal the final bit of the previous frame, or 0 after IDLE.
REQ-017 A frame load SHALL occur on RUN entry, and on a falling event with k=2*SLOT-1 while enable=1; on a frame load the block SHALL:
- set k=0;
- sample mode;
- pulse frame_start;
- move the buffer into the shift register and clear buffer_full.
REQ-018 On a frame load with an empty buffer, the block SHALL load zeros and pulse underrun.
REQ-019 A new input handshake in the same cycle as a frame load SHALL fill the buffer and SHALL NOT bypass into the current frame.
REQ-020 A full buffer emptied by a frame load SHALL keep tx_ready=0 in that cycle; there is no simultaneous refill.
REQ-021 If enable=0 at a falling event with k=2*SLOT-1, the block SHALL return to IDLE with no frame load; enable deassertion mid-frame SHALL NOT truncate the frame.
REQ-022 A change of mode mid-frame SHALL take effect only at the next frame load.

Reset
REQ-023 On nreset=0, the block SHALL asynchronously enter IDLE and clear the buffer, k and the divider.
- sclk, lrclk, sd, frame_start and underrun SHALL be 0.
- tx_ready SHALL be 1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame and its buffered sample without emitting further bits.

Verification
REQ-025 The bench SHALL cover these scenarios (WIDTH=16, SLOT=16, CLKDIV=2 unless stated):
- Write L=0xA5C3, R=0x0F0F; enable=1; mode=1 -> sd reads 1010010111000011 with lrclk=0, then 0000111100001111 with lrclk=1; frame length 128 clocks.
- Same data, mode=0 -> left MSB appears at k=1 and right MSB at k=17; sd=0 at the first k=0.
- enable=1 with no writes -> underrun pulses at RUN entry and every 128 clocks; sd stays 0.
- WIDTH=12, SLOT=16, L=0xFFF -> sd=1 for 12 bits, then 0 for 4 bits.
- Deassert enable at k=5 -> frame completes to k=31, then IDLE; no frame_start follows.
- Reset at k=20 with buffer full -> all outputs 0 and tx_ready=1 immediately; restart shows underrun if no write follows.
